// File: rtl/lcb_distributor.sv
// Round-robin arbiter giving two LCB word-combiner channels turns on the shared
// frame-buffer write / read-modify-write port, with a hold watchdog and misuse flags.
//
// state | meaning
// IDLE  | no owner; comm* driven to 0, arbitration on busy_1 / busy_2
// OWN1  | channel 1 owns the port; comm* pass channel 1 through
// OWN2  | channel 2 owns the port; comm* pass channel 2 through
module lcb_distributor #(
  parameter int AW       = 10,
  parameter int DW       = 12,
  parameter int MAX_HOLD = 4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          busy_1,
  input  logic          busy_2,
  output logic          gnt_1,
  output logic          gnt_2,
  input  logic [DW-1:0] wrdOut_1,
  input  logic [AW-1:0] wrdAddr_1,
  input  logic          wren_1,
  input  logic [AW-1:0] oldWrdAddr_1,
  input  logic          oldRdEn_1,
  output logic [DW-1:0] oldWrd_1,
  input  logic [DW-1:0] wrdOut_2,
  input  logic [AW-1:0] wrdAddr_2,
  input  logic          wren_2,
  input  logic [AW-1:0] oldWrdAddr_2,
  input  logic          oldRdEn_2,
  output logic [DW-1:0] oldWrd_2,
  output logic [DW-1:0] commWrdOut,
  output logic [AW-1:0] commWrdAddr,
  output logic          commWren,
  output logic [AW-1:0] commOldWrdAddr,
  output logic          commOldRdEn,
  input  logic [DW-1:0] commOldWrd,
  output logic          timeout_1,
  output logic          timeout_2,
  output logic          viol_1,
  output logic          viol_2
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW:0] HOLD_MAX = (CW+1)'(MAX_HOLD);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN1 = 2'd1;
  localparam logic [1:0] S_OWN2 = 2'd2;

  logic [1:0]    state, state_nxt;
  logic          last_2, last_2_nxt;
  logic [CW-1:0] hold_cnt, hold_cnt_nxt;
  logic [CW:0]   hold_inc;
  logic          lockout_1, lockout_1_nxt;
  logic          lockout_2, lockout_2_nxt;
  logic          timeout_1_nxt, timeout_2_nxt;
  logic          elig_1, elig_2;

  assign elig_1   = busy_1 & ~lockout_1;
  assign elig_2   = busy_2 & ~lockout_2;
  assign hold_inc = {1'b0, hold_cnt} + {{CW{1'b0}}, 1'b1};

  always_comb begin
    state_nxt     = state;
    last_2_nxt    = last_2;
    hold_cnt_nxt  = hold_cnt;
    lockout_1_nxt = lockout_1 & busy_1;
    lockout_2_nxt = lockout_2 & busy_2;
    timeout_1_nxt = 1'b0;
    timeout_2_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        hold_cnt_nxt = '0;
        if (elig_1 && elig_2) state_nxt = last_2 ? S_OWN1 : S_OWN2;
        else if (elig_1)      state_nxt = S_OWN1;
        else if (elig_2)      state_nxt = S_OWN2;
      end
      S_OWN1: begin
        if (!busy_1) begin
          state_nxt  = S_IDLE;
          last_2_nxt = 1'b0;
        end else if (hold_inc == HOLD_MAX) begin
          state_nxt     = S_IDLE;
          last_2_nxt    = 1'b0;
          lockout_1_nxt = 1'b1;
          timeout_1_nxt = 1'b1;
        end else begin
          hold_cnt_nxt = hold_inc[CW-1:0];
        end
      end
      S_OWN2: begin
        if (!busy_2) begin
          state_nxt  = S_IDLE;
          last_2_nxt = 1'b1;
        end else if (hold_inc == HOLD_MAX) begin
          state_nxt     = S_IDLE;
          last_2_nxt    = 1'b1;
          lockout_2_nxt = 1'b1;
          timeout_2_nxt = 1'b1;
        end else begin
          hold_cnt_nxt = hold_inc[CW-1:0];
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // last_2 = 1 means channel 2 was served last, so channel 1 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      last_2    <= 1'b1;
      hold_cnt  <= '0;
      lockout_1 <= 1'b0;
      lockout_2 <= 1'b0;
      timeout_1 <= 1'b0;
      timeout_2 <= 1'b0;
      viol_1    <= 1'b0;
      viol_2    <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_2    <= last_2_nxt;
      hold_cnt  <= hold_cnt_nxt;
      lockout_1 <= lockout_1_nxt;
      lockout_2 <= lockout_2_nxt;
      timeout_1 <= timeout_1_nxt;
      timeout_2 <= timeout_2_nxt;
      viol_1    <= (wren_1 | oldRdEn_1) & ~gnt_1;
      viol_2    <= (wren_2 | oldRdEn_2) & ~gnt_2;
    end
  end

  assign gnt_1 = (state == S_OWN1);
  assign gnt_2 = (state == S_OWN2);

  always_comb begin
    commWrdOut     = '0;
    commWrdAddr    = '0;
    commWren       = 1'b0;
    commOldWrdAddr = '0;
    commOldRdEn    = 1'b0;
    if (gnt_1) begin
      commWrdOut     = wrdOut_1;
      commWrdAddr    = wrdAddr_1;
      commWren       = wren_1;
      commOldWrdAddr = oldWrdAddr_1;
      commOldRdEn    = oldRdEn_1;
    end else if (gnt_2) begin
      commWrdOut     = wrdOut_2;
      commWrdAddr    = wrdAddr_2;
      commWren       = wren_2;
      commOldWrdAddr = oldWrdAddr_2;
      commOldRdEn    = oldRdEn_2;
    end
  end

  // only the owner has a read outstanding, so read data is simply broadcast
  assign oldWrd_1 = commOldWrd;
  assign oldWrd_2 = commOldWrd;

endmodule

// File: tb/tb_lcb_distributor.sv
// Directed and randomized checks of lcb_distributor against a transaction-level
// ownership model (who owns the port, how long, who was served last).
module tb_lcb_distributor;
  localparam int AW = 10;
  localparam int DW = 12;
  localparam int MAX_HOLD = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          busy_1 = 0, busy_2 = 0;
  logic          gnt_1, gnt_2;
  logic [DW-1:0] wrdOut_1 = '0, wrdOut_2 = '0;
  logic [AW-1:0] wrdAddr_1 = '0, wrdAddr_2 = '0;
  logic          wren_1 = 0, wren_2 = 0;
  logic [AW-1:0] oldWrdAddr_1 = '0, oldWrdAddr_2 = '0;
  logic          oldRdEn_1 = 0, oldRdEn_2 = 0;
  logic [DW-1:0] oldWrd_1, oldWrd_2;
  logic [DW-1:0] commWrdOut;
  logic [AW-1:0] commWrdAddr;
  logic          commWren;
  logic [AW-1:0] commOldWrdAddr;
  logic          commOldRdEn;
  logic [DW-1:0] commOldWrd = '0;
  logic          timeout_1, timeout_2, viol_1, viol_2;

  int n_assert = 0;
  int n_fail = 0;

  lcb_distributor #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .busy_1(busy_1), .busy_2(busy_2), .gnt_1(gnt_1), .gnt_2(gnt_2),
    .wrdOut_1(wrdOut_1), .wrdAddr_1(wrdAddr_1), .wren_1(wren_1),
    .oldWrdAddr_1(oldWrdAddr_1), .oldRdEn_1(oldRdEn_1), .oldWrd_1(oldWrd_1),
    .wrdOut_2(wrdOut_2), .wrdAddr_2(wrdAddr_2), .wren_2(wren_2),
    .oldWrdAddr_2(oldWrdAddr_2), .oldRdEn_2(oldRdEn_2), .oldWrd_2(oldWrd_2),
    .commWrdOut(commWrdOut), .commWrdAddr(commWrdAddr), .commWren(commWren),
    .commOldWrdAddr(commOldWrdAddr), .commOldRdEn(commOldRdEn), .commOldWrd(commOldWrd),
    .timeout_1(timeout_1), .timeout_2(timeout_2), .viol_1(viol_1), .viol_2(viol_2)
  );

  always #5 clk = ~clk;

  // ownership model: owner 0 = nobody; owned = cycles the current owner has held the port
  int owner, last_served, owned;
  bit locked[1:2];
  bit exp_to[1:2];
  bit exp_viol[1:2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0; last_served = 2; owned = 0;
    locked[1] = 0; locked[2] = 0;
    exp_to[1] = 0; exp_to[2] = 0;
    exp_viol[1] = 0; exp_viol[2] = 0;
  endtask

  task automatic check_all();
    logic [DW-1:0] e_wd;
    logic [AW-1:0] e_wa, e_ra;
    logic e_we, e_re;
    e_wd = '0; e_wa = '0; e_we = 0; e_ra = '0; e_re = 0;
    if (owner == 1) begin
      e_wd = wrdOut_1; e_wa = wrdAddr_1; e_we = wren_1; e_ra = oldWrdAddr_1; e_re = oldRdEn_1;
    end else if (owner == 2) begin
      e_wd = wrdOut_2; e_wa = wrdAddr_2; e_we = wren_2; e_ra = oldWrdAddr_2; e_re = oldRdEn_2;
    end
    chk("gnt_1", gnt_1, owner == 1);
    chk("gnt_2", gnt_2, owner == 2);
    chk("commWrdOut", commWrdOut, e_wd);
    chk("commWrdAddr", commWrdAddr, e_wa);
    chk("commWren", commWren, e_we);
    chk("commOldWrdAddr", commOldWrdAddr, e_ra);
    chk("commOldRdEn", commOldRdEn, e_re);
    chk("oldWrd_1", oldWrd_1, commOldWrd);
    chk("oldWrd_2", oldWrd_2, commOldWrd);
    chk("timeout_1", timeout_1, exp_to[1]);
    chk("timeout_2", timeout_2, exp_to[2]);
    chk("viol_1", viol_1, exp_viol[1]);
    chk("viol_2", viol_2, exp_viol[2]);
  endtask

  task automatic model_advance();
    bit busy[1:2];
    bit strobe[1:2];
    busy[1] = busy_1; busy[2] = busy_2;
    strobe[1] = wren_1 | oldRdEn_1; strobe[2] = wren_2 | oldRdEn_2;
    if (reset) begin
      model_reset();
    end else begin
      for (int k = 1; k <= 2; k++) begin
        exp_viol[k] = strobe[k] && (owner != k);
        exp_to[k] = 0;
      end
      if (owner == 0) begin
        owned = 0;
        if (busy[1] && !locked[1] && busy[2] && !locked[2]) owner = (last_served == 1) ? 2 : 1;
        else if (busy[1] && !locked[1]) owner = 1;
        else if (busy[2] && !locked[2]) owner = 2;
      end else begin
        owned++;
        if (!busy[owner]) begin
          last_served = owner; owner = 0;
        end else if (owned == MAX_HOLD) begin
          locked[owner] = 1; exp_to[owner] = 1;
          last_served = owner; owner = 0;
        end
      end
      for (int k = 1; k <= 2; k++) if (!busy[k]) locked[k] = 0;
    end
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic advance();
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic clear_inputs();
    busy_1 = 0; busy_2 = 0; wren_1 = 0; wren_2 = 0; oldRdEn_1 = 0; oldRdEn_2 = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    model_reset();
    settle();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic wait_gnt(int k, string tag);
    for (int i = 0; i < 8; i++) begin
      if (owner == k) break;
      step();
    end
    chk(tag, (k == 1) ? gnt_1 : gnt_2, 1);
  endtask

  initial begin
    int seq[$];
    int got1, got2, ngnt, nto;
    bit p1, p2;
    model_reset();
    @(negedge clk);
    settle();
    chk("reset_gnt", {gnt_2, gnt_1}, 0);
    chk("reset_pulses", {timeout_2, timeout_1, viol_2, viol_1}, 0);
    @(negedge clk);
    reset = 0;

    // single channel write, one-cycle grant latency, zero-latency passthrough
    busy_1 = 1;
    settle();
    chk("grant_latency_low", gnt_1, 0);
    advance();
    wren_1 = 1; wrdAddr_1 = 10'h155; wrdOut_1 = 12'hABC;
    settle();
    chk("t1_gnt", gnt_1, 1);
    chk("t1_addr", commWrdAddr, 10'h155);
    chk("t1_data", commWrdOut, 12'hABC);
    chk("t1_wren", commWren, 1);
    advance();
    wren_1 = 0; busy_1 = 0;
    step();
    step();

    // repeated contention alternates, starting with ch1 after reset
    do_reset();
    p1 = 0; p2 = 0;
    for (int rep = 0; rep < 3; rep++) begin
      busy_1 = 1; busy_2 = 1; got1 = 0; got2 = 0;
      for (int c = 0; c < 40 && (busy_1 || busy_2); c++) begin
        if (owner == 1) begin got1++; if (got1 == 5) busy_1 = 0; end
        if (owner == 2) begin got2++; if (got2 == 5) busy_2 = 0; end
        settle();
        if (gnt_1 && !p1) seq.push_back(1);
        if (gnt_2 && !p2) seq.push_back(2);
        chk("no_dual_grant", gnt_1 & gnt_2, 0);
        p1 = gnt_1; p2 = gnt_2;
        advance();
      end
      chk("contention_done", {busy_2, busy_1}, 0);
      step();
      p1 = gnt_1; p2 = gnt_2;
    end
    chk("grant_count", seq.size(), 6);
    for (int i = 0; i < seq.size() && i < 6; i++) chk("grant_order", seq[i], (i % 2 == 0) ? 1 : 2);

    // watchdog on ch2
    busy_2 = 1; ngnt = 0; nto = 0;
    for (int c = 0; c < 40; c++) begin
      settle();
      if (gnt_2) ngnt++;
      if (timeout_2) nto++;
      advance();
    end
    chk("wd_gnt_cycles", ngnt, MAX_HOLD);
    chk("wd_timeout_pulses", nto, 1);
    busy_2 = 0;
    step();
    busy_2 = 1;
    step();
    settle();
    chk("wd_regrant", gnt_2, 1);
    busy_2 = 0;
    advance();
    step();

    // ch2 strobes while ch1 owns the port
    busy_1 = 1;
    wait_gnt(1, "viol_gnt1");
    wren_1 = 1; wrdAddr_1 = 10'h0A0; wrdOut_1 = 12'h111;
    wren_2 = 1; wrdAddr_2 = 10'h2F0; wrdOut_2 = 12'hEEE;
    settle();
    chk("viol_addr", commWrdAddr, 10'h0A0);
    chk("viol_data", commWrdOut, 12'h111);
    advance();
    wren_1 = 0;
    settle();
    chk("viol_pulse1", viol_2, 1);
    chk("viol_wren_ch2_blocked", commWren, 0);
    advance();
    wren_2 = 0;
    settle();
    chk("viol_pulse2", viol_2, 1);
    advance();
    settle();
    chk("viol_end", viol_2, 0);
    busy_1 = 0;
    advance();

    // read-modify-write by ch2
    busy_2 = 1;
    wait_gnt(2, "rmw_gnt2");
    oldRdEn_2 = 1; oldWrdAddr_2 = 10'h3FF;
    settle();
    chk("rmw_rd_en", commOldRdEn, 1);
    chk("rmw_rd_addr", commOldWrdAddr, 10'h3FF);
    advance();
    oldRdEn_2 = 0; commOldWrd = 12'h7E1;
    settle();
    chk("rmw_rd_data", oldWrd_2, 12'h7E1);
    advance();
    wren_2 = 1; wrdAddr_2 = 10'h3FF; wrdOut_2 = 12'h7E3;
    settle();
    chk("rmw_wr_data", commWrdOut, 12'h7E3);
    chk("rmw_wr_addr", commWrdAddr, 10'h3FF);
    chk("rmw_wr_en", commWren, 1);
    advance();
    wren_2 = 0; busy_2 = 0;
    step();

    // asynchronous reset during an ch1 write
    busy_1 = 1;
    wait_gnt(1, "rst_gnt1");
    wren_1 = 1;
    settle();
    #2;
    reset = 1;
    model_reset();
    #1;
    check_all();
    chk("rst_mid_gnt", gnt_1, 0);
    chk("rst_mid_wren", commWren, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 0; clear_inputs(); busy_2 = 1;
    step();
    settle();
    chk("rst_then_gnt2", gnt_2, 1);
    busy_2 = 0;
    advance();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) busy_1 = ~busy_1;
      if ($urandom_range(0, 7) == 0) busy_2 = ~busy_2;
      wren_1 = ($urandom_range(0, 2) == 0); oldRdEn_1 = ($urandom_range(0, 3) == 0);
      wren_2 = ($urandom_range(0, 2) == 0); oldRdEn_2 = ($urandom_range(0, 3) == 0);
      wrdOut_1 = DW'($urandom); wrdAddr_1 = AW'($urandom); oldWrdAddr_1 = AW'($urandom);
      wrdOut_2 = DW'($urandom); wrdAddr_2 = AW'($urandom); oldWrdAddr_2 = AW'($urandom);
      commOldWrd = DW'($urandom);
      if (reset) reset = 0;
      else if ($urandom_range(0, 599) == 0) begin
        reset = 1;
        model_reset();
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
